// File: rtl/ui565_888_unpack_ctrl.sv
// RGB565 pair unpacker: splits each 32-bit word into two pixels and expands them to RGB888 with frame/line markers.
// States: IDLE wait frame_start | EMPTY need a word | PIX0/PIX1 emit first/second half | DONE frame_done pulse.
module ui565_888_unpack_ctrl #(
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 768,
  parameter int WORD_ORDER = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        cfg_complement,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_eof,
  output logic        busy,
  output logic        frame_done
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam bit SWAP = (WORD_ORDER != 0);

  typedef enum logic [2:0] {S_IDLE, S_EMPTY, S_PIX0, S_PIX1, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     word_q, word_d;
  logic            mode_q, mode_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            second;
  logic            last_x, last_pix;
  logic [15:0]     pix;

  function automatic logic [23:0] expand(input logic [15:0] p, input logic m);
    logic [4:0] r5, b5;
    logic [5:0] g6;
    r5 = p[15:11];
    g6 = p[10:5];
    b5 = p[4:0];
    if (m) expand = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    else   expand = {r5, 3'b000, g6, 2'b00, b5, 3'b000};
  endfunction

  assign last_x   = (x_q == X_LAST);
  assign last_pix = last_x && (y_q == Y_LAST);

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    mode_d     = mode_q;
    x_d        = x_q;
    y_d        = y_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    second     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (frame_start) begin
          mode_d  = cfg_complement;
          x_d     = '0;
          y_d     = '0;
          state_d = S_EMPTY;
        end
      end
      S_EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = in_data;
          state_d = S_PIX0;
        end
      end
      S_PIX0: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_PIX1;
      end
      S_PIX1: begin
        out_valid = 1'b1;
        second    = 1'b1;
        // The final word has already been used: refuse the next frame's data.
        in_ready  = out_ready && !last_pix;
        if (out_ready) begin
          if (last_pix) begin
            state_d = S_DONE;
          end else if (in_valid) begin
            word_d  = in_data;
            state_d = S_PIX0;
          end else begin
            state_d = S_EMPTY;
          end
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    if (out_valid && out_ready) begin
      if (last_x) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  assign pix      = (second ^ SWAP) ? word_q[31:16] : word_q[15:0];
  assign out_data = expand(pix, mode_q);
  assign out_sof  = out_valid && (x_q == '0) && (y_q == '0);
  assign out_eol  = out_valid && last_x;
  assign out_eof  = out_valid && last_pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

endmodule

// File: tb/tb_ui565_888_unpack_ctrl.sv
// Bench for ui565_888_unpack_ctrl: two instances (both word orders) on a 4x2 frame, table vectors plus random
// frames scored against an arithmetic pixel model and a per-frame handshake model.
module tb_ui565_888_unpack_ctrl;

  localparam int H_T  = 4;
  localparam int V_T  = 2;
  localparam int NPIX = H_T * V_T;
  localparam int NW   = NPIX / 2;

  logic        clk = 1'b0;
  logic        rst, frame_start, cfg_complement, out_ready;
  logic [31:0] in_data_w [2];
  logic [1:0]  in_valid_w, in_ready_w, out_valid_w, sof_w, eol_w, eof_w, busy_w, done_w;
  logic [23:0] out_data_w [2];

  always #5 clk = ~clk;

  ui565_888_unpack_ctrl #(.H_ACTIVE(H_T), .V_ACTIVE(V_T), .WORD_ORDER(0)) dut0 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .cfg_complement(cfg_complement),
    .in_data(in_data_w[0]), .in_valid(in_valid_w[0]), .in_ready(in_ready_w[0]),
    .out_data(out_data_w[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_sof(sof_w[0]), .out_eol(eol_w[0]), .out_eof(eof_w[0]),
    .busy(busy_w[0]), .frame_done(done_w[0]));

  ui565_888_unpack_ctrl #(.H_ACTIVE(H_T), .V_ACTIVE(V_T), .WORD_ORDER(1)) dut1 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .cfg_complement(cfg_complement),
    .in_data(in_data_w[1]), .in_valid(in_valid_w[1]), .in_ready(in_ready_w[1]),
    .out_data(out_data_w[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_sof(sof_w[1]), .out_eol(eol_w[1]), .out_eof(eof_w[1]),
    .busy(busy_w[1]), .frame_done(done_w[1]));

  typedef struct {
    bit          mode;
    logic [31:0] word;
    logic [23:0] exp_lo;
    logic [23:0] exp_hi;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] fw [NW];
  bit          tbl_mode;
  int          tbl_base;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          first_hs, last_hs;
  bit          chk_en = 0;
  bit          rst_prev = 0;

  bit          mbusy [2];
  bit          mdone [2];
  bit          mmode [2];
  bit          stall_prev [2];
  int          mwords [2];
  int          mpix [2];
  logic [26:0] prev_out [2];
  logic [26:0] q0 [$];
  logic [26:0] q1 [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void qpush(input int k, input logic [26:0] v);
    if (k == 0) q0.push_back(v);
    else        q1.push_back(v);
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [26:0] qpop(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Reference expansion written as plain arithmetic on the channel values.
  function automatic logic [23:0] ref_expand(input logic [15:0] p, input bit m);
    int r, g, b, r8, g8, b8;
    r  = int'(p) / 2048;
    g  = (int'(p) / 32) % 64;
    b  = int'(p) % 32;
    r8 = r * 8 + (m ? r / 4 : 0);
    g8 = g * 4 + (m ? g / 16 : 0);
    b8 = b * 8 + (m ? b / 4 : 0);
    return 24'(r8 * 65536 + g8 * 256 + b8);
  endfunction

  function automatic logic [2:0] ref_flags(input int p);
    return {p == 0, (p % H_T) == H_T - 1, p == NPIX - 1};
  endfunction

  task automatic sample_lane(input int k, input bit fs, input bit cfg, input bit rdy, input bit r);
    logic [26:0] got;
    logic [23:0] dlo, dhi, dfirst, dsecond;
    bit          nd;
    int          p;
    nd  = 0;
    got = {sof_w[k], eol_w[k], eof_w[k], out_data_w[k]};
    if (chk_en) begin
      chk($sformatf("busy_l%0d", k), 32'(busy_w[k]), 32'(mbusy[k]));
      chk($sformatf("frame_done_l%0d", k), 32'(done_w[k]), 32'(mdone[k]));
      if (!mbusy[k]) begin
        chk($sformatf("idle_in_ready_l%0d", k), 32'(in_ready_w[k]), 0);
        chk($sformatf("idle_out_valid_l%0d", k), 32'(out_valid_w[k]), 0);
      end
      if (mwords[k] == NW) chk($sformatf("in_ready_after_last_word_l%0d", k), 32'(in_ready_w[k]), 0);
      if (rst_prev) chk($sformatf("reset_outputs_l%0d", k), 32'(got), 0);
      if (stall_prev[k]) begin
        chk($sformatf("stall_valid_l%0d", k), 32'(out_valid_w[k]), 1);
        chk($sformatf("stall_hold_l%0d", k), 32'(got), 32'(prev_out[k]));
      end
      if (out_valid_w[k] === 1'b1 && rdy) begin
        if (qsize(k) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel_l%0d: got %h expected no pixel (cycle %0d)", k, got, cyc);
        end else begin
          chk($sformatf("pixel_l%0d", k), 32'(got), 32'(qpop(k)));
        end
        mpix[k]++;
        if (mpix[k] == NPIX) nd = 1;
        if (k == 0) begin
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
        end
      end
      if (in_valid_w[k] === 1'b1 && in_ready_w[k] === 1'b1) begin
        p = 2 * mwords[k];
        if (tbl_mode) begin
          dlo = tbl[tbl_base + mwords[k]].exp_lo;
          dhi = tbl[tbl_base + mwords[k]].exp_hi;
        end else begin
          dlo = ref_expand(fw[mwords[k]][15:0], mmode[k]);
          dhi = ref_expand(fw[mwords[k]][31:16], mmode[k]);
        end
        dfirst  = (k == 0) ? dlo : dhi;
        dsecond = (k == 0) ? dhi : dlo;
        qpush(k, {ref_flags(p), dfirst});
        qpush(k, {ref_flags(p + 1), dsecond});
        mwords[k]++;
      end
    end
    stall_prev[k] = chk_en && (out_valid_w[k] === 1'b1) && !rdy && !r;
    prev_out[k]   = got;
    if (r) begin
      mbusy[k]  = 0;
      nd        = 0;
      mwords[k] = 0;
      mpix[k]   = 0;
      if (k == 0) q0.delete();
      else        q1.delete();
    end else if (!mbusy[k] && fs) begin
      mbusy[k]  = 1;
      mmode[k]  = cfg;
      mwords[k] = 0;
      mpix[k]   = 0;
    end else if (mdone[k]) begin
      mbusy[k] = 0;
    end
    mdone[k] = nd;
  endtask

  task automatic step(input bit fs, input bit cfg, input bit ven, input bit rdy, input bit r);
    @(negedge clk);
    frame_start    = fs;
    cfg_complement = cfg;
    out_ready      = rdy;
    rst            = r;
    for (int k = 0; k < 2; k++) begin
      in_valid_w[k] = ven && (mwords[k] < NW);
      in_data_w[k]  = fw[(mwords[k] < NW) ? mwords[k] : 0];
    end
    #1;
    for (int k = 0; k < 2; k++) sample_lane(k, fs, cfg, rdy, r);
    rst_prev = r;
    cyc++;
  endtask

  task automatic run_frame(input bit use_tbl, input int tf, input bit rnd);
    bit m;
    int n, start_cyc;
    if (use_tbl) begin
      for (int i = 0; i < NW; i++) fw[i] = tbl[tf * NW + i].word;
      m = tbl[tf * NW].mode;
    end else begin
      for (int i = 0; i < NW; i++) fw[i] = $urandom;
      m = 1'($urandom_range(0, 1));
    end
    tbl_mode  = use_tbl;
    tbl_base  = tf * NW;
    first_hs  = -1;
    last_hs   = -1;
    start_cyc = cyc;
    step(1, m, 1, 1, 0);
    n = 0;
    while ((mbusy[0] || mbusy[1]) && n < 300) begin
      if (rnd) step($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)), 0);
      else     step(0, m, 1, 1, 0);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got still busy after %0d cycles expected idle", n);
    end
    for (int k = 0; k < 2; k++) chk($sformatf("leftover_pixels_l%0d", k), 32'(qsize(k)), 0);
    if (!rnd) begin
      chk("first_pixel_latency", 32'(first_hs - start_cyc), 2);
      chk("back_to_back_span", 32'(last_hs - first_hs), NPIX - 1);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h07E0_F800, 24'hFF0000, 24'h00FF00};
    tbl[1] = '{1'b1, 32'h001F_8410, 24'h848284, 24'h0000FF};
    tbl[2] = '{1'b1, 32'h1234_ABCD, 24'hAD796B, 24'h1045A5};
    tbl[3] = '{1'b1, 32'hFFFF_FFFF, 24'hFFFFFF, 24'hFFFFFF};
    tbl[4] = '{1'b0, 32'h07E0_F800, 24'hF80000, 24'h00FC00};
    tbl[5] = '{1'b0, 32'h001F_8410, 24'h808080, 24'h0000F8};
    tbl[6] = '{1'b0, 32'h0821_0821, 24'h080408, 24'h080408};
    tbl[7] = '{1'b0, 32'h0000_0000, 24'h000000, 24'h000000};
    for (int i = 0; i < NW; i++) fw[i] = '0;
    for (int k = 0; k < 2; k++) begin
      mbusy[k] = 0; mdone[k] = 0; mmode[k] = 0; stall_prev[k] = 0;
      mwords[k] = 0; mpix[k] = 0; prev_out[k] = '0;
    end
    tbl_mode = 0;
    tbl_base = 0;
    frame_start = 0; cfg_complement = 0; out_ready = 0; rst = 1;
    in_valid_w = '0;
    in_data_w[0] = '0;
    in_data_w[1] = '0;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk_en = 1;
    step(0, 0, 0, 0, 0);

    for (int f = 0; f < 2; f++) run_frame(1, f, 0);
    step(0, 0, 0, 0, 0);

    // Reset while the second pixel is stalled; the frame must vanish without frame_done.
    for (int i = 0; i < NW; i++) fw[i] = $urandom;
    tbl_mode = 0;
    step(1, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    run_frame(0, 0, 0);

    for (int f = 0; f < 250; f++) run_frame(0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
